gcd_datapath: RTL and testbench

- Iterative subtract-based GCD engine: datapath (A/B registers, comparator, subtractor, input muxing) plus integrated control FSM.
- Takes two unsigned operands serially on one shared input bus after a start request, then repeatedly subtracts the smaller from the larger until they are equal.
- Presents the result with a done flag.
- Sits as a leaf compute block behind a simple start/done handshake.

---
 rtl/gcd_datapath_if.sv | 19 +
 rtl/gcd_datapath.sv | 100 ++++++++++
 tb/tb_gcd_datapath.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gcd_datapath_if.sv
// Start/done handshake bundle for the subtract-based GCD engine.
// iter_count exists only when GCD_ITER_COUNT_EN is defined.
interface gcd_datapath_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] gcd_out;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0]      iter_count;

  modport master (output start, data_in, input done, gcd_out, iter_count);
  modport slave  (input start, data_in, output done, gcd_out, iter_count);
`else
  modport master (output start, data_in, input done, gcd_out);
  modport slave  (input start, data_in, output done, gcd_out);
`endif
endinterface

// File: rtl/gcd_datapath.sv
// Iterative subtract-based GCD engine: A/B datapath with its control FSM.
// Optional GCD_ITER_COUNT_EN adds a saturating subtraction counter on iter_count.
module gcd_datapath #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  gcd_datapath_if.slave   bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoadA = 3'd1;
  localparam logic [2:0] StLoadB = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoadA;
      end
      StLoadA: begin
        a_d     = bus.data_in;
        state_d = StLoadB;
      end
      StLoadB: begin
        b_d     = bus.data_in;
        state_d = StRun;
      end
      StRun: begin
        // Zero checks come first so gcd(0,x)=x and gcd(x,0)=x end in one cycle.
        if (a_q == '0) begin
          a_d     = b_q;
          state_d = StDone;
        end else if (b_q == '0) begin
          state_d = StDone;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else if (a_q < b_q) begin
          b_d = b_q - a_q;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!bus.start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.done    = (state_q == StDone);
  assign bus.gcd_out = a_q;

`ifdef GCD_ITER_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        run_sub;

  assign run_sub = (state_q == StRun) && (a_q != '0) && (b_q != '0) && (a_q != b_q);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StLoadA) begin
      cnt_d = '0;
    end else if (run_sub && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.iter_count = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath: directed cases plus random operand pairs
// checked against a Euclid-based reference model.
module tb_gcd_datapath;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned TIMEOUT = 70000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  gcd_datapath_if #(.WIDTH(WIDTH)) bus ();

  gcd_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: gcd via modulo Euclid; subtraction steps are the sum of quotients
  // minus one (the final equal pair terminates instead of subtracting).
  function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                  output int unsigned g, output int unsigned subs);
    int unsigned x, y, t, qsum;
    if (a == 0) begin
      g = b; subs = 0;
    end else if (b == 0) begin
      g = a; subs = 0;
    end else begin
      x = a; y = b; qsum = 0;
      while (y != 0) begin
        qsum += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x; subs = qsum - 1;
    end
  endfunction

  // Drives start and both operands; returns just after the B-load edge.
  task automatic load_ops(input int unsigned a, input int unsigned b);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.data_in = WIDTH'(a);
    @(negedge clk);
    bus.data_in = WIDTH'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int unsigned a, input int unsigned b);
    int unsigned g, subs, cycles;
    ref_gcd(a, b, g, subs);
    cycles = 0;
    while (!bus.done && cycles < TIMEOUT) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_gcd"}, 32'(bus.gcd_out), g);
    check_eq({tag, "_lat"}, cycles, subs + 1);
`ifdef GCD_ITER_COUNT_EN
    check_eq({tag, "_iter"}, 32'(bus.iter_count), (subs > 65535) ? 65535 : subs);
`endif
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_idle"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_case(input string tag, input int unsigned a, input int unsigned b);
    load_ops(a, b);
    wait_done(tag, a, b);
    release_start(tag);
  endtask

  initial begin
    int unsigned g0, ra, rb;
    logic [WIDTH-1:0] held;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.start   = 1'b1;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_gcd", 32'(bus.gcd_out), 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check_eq("rst_iter", 32'(bus.iter_count), 32'd0);
`endif
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_case("basic", 143, 78);
    run_case("equal", 50, 50);
    run_case("zero_a", 0, 36);
    run_case("zero_b", 36, 0);
    run_case("zero_ab", 0, 0);

    // Handshake: DONE persists while start stays high.
    load_ops(100, 75);
    wait_done("hold", 100, 75);
    held = bus.gcd_out;
    repeat (4) @(posedge clk);
    #1;
    check_eq("hold_done", 32'(bus.done), 32'd1);
    check_eq("hold_gcd", 32'(bus.gcd_out), 32'(held));
    release_start("hold");
    run_case("restart", 48, 18);

    // Reset in the middle of RUN aborts everything.
    load_ops(143, 78);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_gcd", 32'(bus.gcd_out), 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check_eq("midrst_iter", 32'(bus.iter_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("postrst_done", 32'(bus.done), 32'd0);
    run_case("fresh", 21, 14);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom_range(0, 1000);
      rb = $urandom_range(0, 1000);
      g0 = 0;
      run_case($sformatf("rnd%0d", i), ra, rb);
    end

    run_case("extreme", 65535, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
